// File: rtl/z80_io_timer.sv
// z80_io_timer: programmable 16-bit interval timer on the Z80 I/O bus.
// Counts cpu_clk cycles, optionally through a fixed prescaler. Raises a level
// interrupt request when the down-counter reaches its terminal count.
// Register map (addr): 0 CTRL, 1 LO, 2 HI (snapshot on read), 3 STATUS.
module z80_io_timer #(
  parameter int unsigned PRESCALE = 16
) (
  input  logic       cpu_clk,
  input  logic       n_RST,
  input  logic       ce,
  input  logic       rd,
  input  logic       wr,
  input  logic [1:0] addr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       intreq,
  input  logic       intack
);

  localparam int unsigned   PW      = $clog2(PRESCALE);
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_LO     = 2'd1,
    REG_HI     = 2'd2,
    REG_STATUS = 2'd3
  } reg_sel_e;

  // Field order puts EN at bit 0 so the struct maps directly onto CTRL[3:0].
  typedef struct packed {
    logic ps;
    logic ie;
    logic auto_rl;
    logic en;
  } ctrl_t;

  ctrl_t          ctrl;
  logic [15:0]    reload;
  logic [15:0]    cnt;
  logic [PW-1:0]  presc;
  logic [7:0]     snapshot;
  logic           zf;

  logic           wr_q;
  logic           rd_q;
  reg_sel_e       rd_sel;

  reg_sel_e       sel;
  logic           wr_act;
  logic           rd_act;
  logic           wr_ev;
  logic           rd_clr;
  logic           ctrl_wr;
  logic           lo_wr;
  logic           hi_wr;
  logic           tick;
  logic           tc;

  assign sel    = reg_sel_e'(addr);
  assign wr_act = ce & wr;
  assign rd_act = ce & rd;

  // A write acts once per access, on the rising edge of the qualified strobe.
  assign wr_ev   = wr_act & ~wr_q;
  assign ctrl_wr = wr_ev & (sel == REG_CTRL);
  assign lo_wr   = wr_ev & (sel == REG_LO);
  assign hi_wr   = wr_ev & (sel == REG_HI);

  // STATUS clears after the CPU has finished sampling, i.e. when the read ends.
  assign rd_clr  = rd_q & ~rd_act & (rd_sel == REG_STATUS);

  // A HI write reloads the counter and swallows any tick in the same cycle.
  assign tick = ctrl.en & (~ctrl.ps | (presc == PS_LAST)) & ~hi_wr;
  assign tc   = tick & (cnt == 16'd1);

  // Registered interrupt request: no combinational path from any input.
  assign intreq = zf & ctrl.ie;

  // Strobe history for edge detection, plus the register a read addressed.
  // NOTE: every clocked process uses non-blocking (<=) assignments so that all
  // registers sample pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge cpu_clk or negedge n_RST) begin
    if (!n_RST) begin
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      rd_sel <= REG_CTRL;
    end else begin
      wr_q <= wr_act;
      rd_q <= rd_act;
      if (rd_act) rd_sel <= sel;
    end
  end

  // Control register; a one-shot terminal count drops EN unless CTRL is written.
  always_ff @(posedge cpu_clk or negedge n_RST) begin
    if (!n_RST) begin
      ctrl <= '0;
    end else if (ctrl_wr) begin
      ctrl <= ctrl_t'(data_in[3:0]);
    end else if (tc && !ctrl.auto_rl) begin
      ctrl.en <= 1'b0;
    end
  end

  // Reload value, written a byte at a time.
  always_ff @(posedge cpu_clk or negedge n_RST) begin
    if (!n_RST) begin
      reload <= 16'h0000;
    end else if (lo_wr) begin
      reload[7:0] <= data_in;
    end else if (hi_wr) begin
      reload[15:8] <= data_in;
    end
  end

  // Prescaler: cleared by CTRL writes, held at 0 unless enabled in PS mode.
  always_ff @(posedge cpu_clk or negedge n_RST) begin
    if (!n_RST) begin
      presc <= '0;
    end else if (ctrl_wr || !ctrl.en || !ctrl.ps) begin
      presc <= '0;
    end else if (presc == PS_LAST) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Down-counter: HI write loads, tick decrements, terminal count reloads or stops.
  always_ff @(posedge cpu_clk or negedge n_RST) begin
    if (!n_RST) begin
      cnt <= 16'h0000;
    end else if (hi_wr) begin
      cnt <= {data_in, reload[7:0]};
    end else if (tc) begin
      cnt <= ctrl.auto_rl ? reload : 16'h0000;
    end else if (tick) begin
      cnt <= cnt - 16'd1;
    end
  end

  // Terminal-count flag; a set in the same cycle as a clear wins.
  always_ff @(posedge cpu_clk or negedge n_RST) begin
    if (!n_RST) begin
      zf <= 1'b0;
    end else if (tc) begin
      zf <= 1'b1;
    end else if (intack || rd_clr) begin
      zf <= 1'b0;
    end
  end

  // High-byte snapshot tracks cnt[15:8] for every cycle a LO read is active,
  // so it always pairs with the low byte of the last sampled read cycle.
  always_ff @(posedge cpu_clk or negedge n_RST) begin
    if (!n_RST) begin
      snapshot <= 8'h00;
    end else if (rd_act && sel == REG_LO) begin
      snapshot <= cnt[15:8];
    end
  end

  // Combinational read mux, driven only while the read strobe is qualified.
  // NOTE: outputs are given a default first so no path leaves them unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    data_out = 8'h00;
    data_oe  = rd_act;
    if (rd_act) begin
      unique case (sel)
        REG_CTRL:   data_out = {4'h0, ctrl};
        REG_LO:     data_out = cnt[7:0];
        REG_HI:     data_out = snapshot;
        REG_STATUS: data_out = {6'b00_0000, ctrl.en, zf};
      endcase
    end
  end

endmodule
